// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants: widths, regfile FSM encoding, ALU control codes
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // Regfile clear-sequencer state encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // ALU control codes shared with RISCVALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/riscv_regfile_if.sv
// rtl/riscv_regfile_if.sv - read/write-back bus between datapath and register file
interface riscv_regfile_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic [riscv_pkg::REG_ADDR_W-1:0] ReadReg1;
    logic [riscv_pkg::REG_ADDR_W-1:0] ReadReg2;
    logic [riscv_pkg::REG_ADDR_W-1:0] WriteReg;
    logic [XLEN-1:0]                  WriteData;
    logic                             RegWrite;
    logic [XLEN-1:0]                  ReadData1;
    logic [XLEN-1:0]                  ReadData2;
    logic                             ready;

    modport master (
        output ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite,
        input  ReadData1, ReadData2, ready
    );

    modport slave (
        input  ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite,
        output ReadData1, ReadData2, ready
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - post-reset sweep that zeroes x1..x31 one register per cycle
module regfile_clear_seq
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    output logic                  clr_en,
    output logic [REG_ADDR_W-1:0] clr_addr
);

    logic [0:0]            state;
    logic [REG_ADDR_W-1:0] ptr;

    // Sweep pointer walks 1..31, then the file is declared usable
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= REG_ADDR_W'(1);
            ready <= 1'b0;
        end else if (state == ST_CLEAR) begin
            if (ptr == REG_ADDR_W'(NUM_REGS - 1)) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end else begin
                ptr <= ptr + REG_ADDR_W'(1);
            end
        end
    end

    // Clear strobe is held off while reset is asserted so the array is untouched at that edge
    always_comb begin
        clr_en   = (state == ST_CLEAR) && !rst;
        clr_addr = ptr;
    end

endmodule

// File: rtl/riscv_regfile.sv
// rtl/riscv_regfile.sv - RV32I integer register file, two async read ports, one write port
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b0
) (
    input logic             clk,
    input logic             rst,
    riscv_regfile_if.slave  bus
);

    logic [XLEN-1:0]       regs [NUM_REGS];
    logic                  ready;
    logic                  clr_en;
    logic [REG_ADDR_W-1:0] clr_addr;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  wb_en;

    regfile_clear_seq u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign bus.ready = ready;

    // Write-back only in RUN and never to x0; writes during the sweep are dropped
    assign wb_en = !rst && ready && bus.RegWrite && (bus.WriteReg != '0);

    // Single write port: the sweep owns it while clearing, write-back otherwise
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.WriteReg;
        wr_data = bus.WriteData;
        if (clr_en) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (wb_en) begin
            wr_en = 1'b1;
        end
    end

    // Array has no reset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Combinational read ports with x0 hardwired to zero and optional write forwarding
    always_comb begin
        bus.ReadData1 = '0;
        bus.ReadData2 = '0;
        if (!rst && ready) begin
            if (bus.ReadReg1 != '0) begin
                bus.ReadData1 = regs[bus.ReadReg1];
                if (BYPASS && bus.RegWrite && (bus.WriteReg == bus.ReadReg1)) begin
                    bus.ReadData1 = bus.WriteData;
                end
            end
            if (bus.ReadReg2 != '0) begin
                bus.ReadData2 = regs[bus.ReadReg2];
                if (BYPASS && bus.RegWrite && (bus.WriteReg == bus.ReadReg2)) begin
                    bus.ReadData2 = bus.WriteData;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_regfile.sv
// tb/tb_riscv_regfile.sv - directed self-checking bench for riscv_regfile, BYPASS=0 and BYPASS=1
module tb_riscv_regfile;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    riscv_regfile_if #(.XLEN(32)) bus0 ();
    riscv_regfile_if #(.XLEN(32)) bus1 ();

    riscv_regfile #(.XLEN(32), .BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    riscv_regfile #(.XLEN(32), .BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Both instances see identical stimulus
    assign bus1.ReadReg1  = bus0.ReadReg1;
    assign bus1.ReadReg2  = bus0.ReadReg2;
    assign bus1.WriteReg  = bus0.WriteReg;
    assign bus1.WriteData = bus0.WriteData;
    assign bus1.RegWrite  = bus0.RegWrite;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] rd, input logic [31:0] data);
        bus0.RegWrite  = en;
        bus0.WriteReg  = rd;
        bus0.WriteData = data;
    endtask

    task automatic set_rd(input logic [4:0] r1, input logic [4:0] r2);
        bus0.ReadReg1 = r1;
        bus0.ReadReg2 = r2;
        #1;
    endtask

    // Runs the 31 sweep edges after reset release; at edge 31 a write to x4 must be dropped
    task automatic sweep_check(input string tag);
        for (int n = 1; n <= 31; n++) begin
            if (n == 31) set_wr(1'b1, 5'd4, 32'hAAAA5555);
            else         set_wr(1'b0, 5'd0, 32'h0);
            if (n > 1) begin
                total++;
                if (bus0.ReadData1 !== 32'h0 || bus0.ReadData2 !== 32'h0 ||
                    bus1.ReadData1 !== 32'h0 || bus1.ReadData2 !== 32'h0) begin
                    bad++;
                    $display("FAIL %s_sweep_read edge=%0d got %h %h %h %h want 0", tag, n - 1,
                             bus0.ReadData1, bus0.ReadData2, bus1.ReadData1, bus1.ReadData2);
                end
            end
            step();
            total++;
            if (bus0.ready !== (n == 31) || bus1.ready !== (n == 31)) begin
                bad++;
                $display("FAIL %s_ready edge=%0d got %b/%b want %b", tag, n,
                         bus0.ready, bus1.ready, (n == 31));
            end
        end
        set_wr(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd1, 5'd31);
        rst = 1'b1;
        step();
        step();
        total++;
        if (bus0.ready !== 1'b0 || bus0.ReadData1 !== 32'h0 || bus1.ReadData2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_state got ready=%b rd1=%h rd2=%h want 0", bus0.ready,
                     bus0.ReadData1, bus1.ReadData2);
        end
        rst = 1'b0;
        sweep_check("reset");
        for (int r = 0; r < 32; r++) begin
            set_rd(5'(r), 5'(31 - r));
            total++;
            if (bus0.ReadData1 !== 32'h0 || bus0.ReadData2 !== 32'h0 ||
                bus1.ReadData1 !== 32'h0 || bus1.ReadData2 !== 32'h0) begin
                bad++;
                $display("FAIL cleared_x%0d got %h %h %h %h want 0", r, bus0.ReadData1,
                         bus0.ReadData2, bus1.ReadData1, bus1.ReadData2);
            end
        end
        // Edge 32 is the first accepted write
        set_wr(1'b1, 5'd2, 32'h0BADF00D);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd2, 5'd4);
        total++;
        if (bus0.ReadData1 !== 32'h0BADF00D || bus1.ReadData1 !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL first_write_x2 got %h/%h want 0badf00d", bus0.ReadData1, bus1.ReadData1);
        end
        total++;
        if (bus0.ReadData2 !== 32'h0 || bus1.ReadData2 !== 32'h0) begin
            bad++;
            $display("FAIL edge31_write_x4 got %h/%h want 00000000", bus0.ReadData2, bus1.ReadData2);
        end
    endtask

    task automatic test_write_read();
        set_wr(1'b1, 5'd5, 32'h0000000F);
        step();
        set_wr(1'b1, 5'd6, 32'h0000000A);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd6);
        total++;
        if (bus0.ReadData1 !== 32'h0000000F || bus0.ReadData2 !== 32'h0000000A ||
            bus1.ReadData1 !== 32'h0000000F || bus1.ReadData2 !== 32'h0000000A) begin
            bad++;
            $display("FAIL write_read got %h %h %h %h want 0000000f 0000000a", bus0.ReadData1,
                     bus0.ReadData2, bus1.ReadData1, bus1.ReadData2);
        end
        total++;
        if ((bus0.ReadData1 & bus0.ReadData2) !== 32'h0000000A) begin
            bad++;
            $display("FAIL alu_and got %h want 0000000a", bus0.ReadData1 & bus0.ReadData2);
        end
    endtask

    task automatic test_x0();
        set_wr(1'b1, 5'd0, 32'hDEADBEEF);
        set_rd(5'd0, 5'd0);
        total++;
        if (bus1.ReadData1 !== 32'h0 || bus1.ReadData2 !== 32'h0) begin
            bad++;
            $display("FAIL x0_bypass got %h %h want 0", bus1.ReadData1, bus1.ReadData2);
        end
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        total++;
        if (bus0.ReadData1 !== 32'h0 || bus0.ReadData2 !== 32'h0 ||
            bus1.ReadData1 !== 32'h0 || bus1.ReadData2 !== 32'h0) begin
            bad++;
            $display("FAIL x0_read got %h %h %h %h want 0", bus0.ReadData1, bus0.ReadData2,
                     bus1.ReadData1, bus1.ReadData2);
        end
    endtask

    task automatic test_bypass();
        set_wr(1'b1, 5'd7, 32'h00000001);
        step();
        set_wr(1'b1, 5'd7, 32'h00000009);
        set_rd(5'd7, 5'd5);
        total++;
        if (bus1.ReadData1 !== 32'h00000009) begin
            bad++;
            $display("FAIL bypass1_pre got %h want 00000009", bus1.ReadData1);
        end
        total++;
        if (bus0.ReadData1 !== 32'h00000001) begin
            bad++;
            $display("FAIL bypass0_pre got %h want 00000001", bus0.ReadData1);
        end
        total++;
        if (bus1.ReadData2 !== 32'h0000000F) begin
            bad++;
            $display("FAIL bypass1_other_port got %h want 0000000f", bus1.ReadData2);
        end
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        total++;
        if (bus0.ReadData1 !== 32'h00000009 || bus1.ReadData1 !== 32'h00000009) begin
            bad++;
            $display("FAIL bypass_post got %h/%h want 00000009", bus0.ReadData1, bus1.ReadData1);
        end
    endtask

    task automatic test_sweep_abort();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            if (n == 5) set_wr(1'b1, 5'd3, 32'h12345678);
            else        set_wr(1'b0, 5'd0, 32'h0);
            step();
        end
        set_wr(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        step();
        total++;
        if (bus0.ready !== 1'b0 || bus1.ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_ready got %b/%b want 0", bus0.ready, bus1.ready);
        end
        rst = 1'b0;
        set_rd(5'd3, 5'd3);
        sweep_check("abort");
        set_rd(5'd3, 5'd7);
        total++;
        if (bus0.ReadData1 !== 32'h0 || bus1.ReadData1 !== 32'h0 ||
            bus0.ReadData2 !== 32'h0 || bus1.ReadData2 !== 32'h0) begin
            bad++;
            $display("FAIL sweep_write_x3 got %h/%h x7 %h/%h want 0", bus0.ReadData1,
                     bus1.ReadData1, bus0.ReadData2, bus1.ReadData2);
        end
    endtask

    task automatic test_reset_in_run();
        set_wr(1'b1, 5'd9, 32'hFFFFFFFF);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd9, 5'd9);
        total++;
        if (bus0.ReadData1 !== 32'hFFFFFFFF || bus1.ReadData2 !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL x9_before_reset got %h/%h want ffffffff", bus0.ReadData1, bus1.ReadData2);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep_check("rerun");
        set_rd(5'd9, 5'd9);
        total++;
        if (bus0.ReadData1 !== 32'h0 || bus0.ReadData2 !== 32'h0 ||
            bus1.ReadData1 !== 32'h0 || bus1.ReadData2 !== 32'h0) begin
            bad++;
            $display("FAIL x9_after_rerun got %h %h %h %h want 0", bus0.ReadData1,
                     bus0.ReadData2, bus1.ReadData1, bus1.ReadData2);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd0, 5'd0);
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_sweep_abort();
        test_reset_in_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
